// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
// Multi-digit BCD up/down counter stepped once per rising edge of a debounced
// button level. Supports wrap or saturate at the limits, a clamped parallel
// load, and a 7-segment pattern per digit (bit 0 = segment a ... bit 6 = g,
// active high).
module bcd_updown_counter #(
  parameter int DIGITS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  dir,
  input  logic                  wrap_en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   leds,
  output logic                  at_zero,
  output logic                  limit
);

  localparam int W = 4 * DIGITS;

  // Step synchroniser and edge detector state.
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_edge;
  logic                   r_armed;

  // Counter state.
  logic [W-1:0]           r_bcd;
  logic                   r_limit;

  logic                   w_sync_last;
  logic                   w_sample_valid;
  logic                   w_pulse;
  logic [W-1:0]           w_inc;
  logic [W-1:0]           w_dec;
  logic [W-1:0]           w_load_clamp;
  logic                   w_all_nine;
  logic                   w_all_zero;
  logic [W-1:0]           w_bcd_next;
  logic                   w_limit_next;

  // Segment pattern for one BCD digit; bit 0 = a, bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // r_fill marks which synchroniser stages hold a real sample taken since
  // reset release, so the zeros left behind by reset never count as the
  // button having been seen low.
  assign w_sync_last    = r_sync[SYNC_STAGES-1];
  assign w_sample_valid = r_fill[SYNC_STAGES-1];
  assign w_pulse        = r_armed & w_sync_last & ~r_edge;

  // Synchronise the button, detect its rising edge, arm only after a genuine low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_edge  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its neighbour; blocking here would collapse the chain.
      r_sync  <= {r_sync[SYNC_STAGES-2:0], step};
      r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_edge  <= w_sync_last;
      r_armed <= r_armed | (w_sample_valid & ~w_sync_last);
    end
  end

  // Digit-serial BCD increment, decrement and load clamp; the final carry and
  // borrow double as the all-nines and all-zeros detectors.
  always_comb begin : b_arith
    logic [3:0] v_dig;
    logic       v_carry;
    logic       v_borrow;
    // NOTE: every output gets a default before any conditional logic so no
    // path leaves a value unassigned, which would infer a latch.
    w_inc        = '0;
    w_dec        = '0;
    w_load_clamp = '0;
    v_dig        = '0;
    v_carry      = 1'b1;
    v_borrow     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      v_dig = r_bcd[4*d +: 4];
      if (!v_carry)            w_inc[4*d +: 4] = v_dig;
      else if (v_dig == 4'd9)  w_inc[4*d +: 4] = 4'd0;
      else begin
        w_inc[4*d +: 4] = v_dig + 4'd1;
        v_carry         = 1'b0;
      end
      if (!v_borrow)           w_dec[4*d +: 4] = v_dig;
      else if (v_dig == 4'd0)  w_dec[4*d +: 4] = 4'd9;
      else begin
        w_dec[4*d +: 4] = v_dig - 4'd1;
        v_borrow        = 1'b0;
      end
      v_dig = load_val[4*d +: 4];
      w_load_clamp[4*d +: 4] = (v_dig > 4'd9) ? 4'd9 : v_dig;
    end
    w_all_nine = v_carry;
    w_all_zero = v_borrow;
  end

  // Next count: load beats a step pulse (which is then dropped), else hold.
  always_comb begin
    w_bcd_next   = r_bcd;
    w_limit_next = 1'b0;
    if (load) begin
      w_bcd_next = w_load_clamp;
    end else if (w_pulse) begin
      if (!dir) begin
        if (w_all_nine) begin
          w_limit_next = 1'b1;
          if (wrap_en) w_bcd_next = w_inc;
        end else begin
          w_bcd_next = w_inc;
        end
      end else begin
        if (w_all_zero) begin
          w_limit_next = 1'b1;
          if (wrap_en) w_bcd_next = w_dec;
        end else begin
          w_bcd_next = w_dec;
        end
      end
    end
  end

  // Count and limit-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcd   <= '0;
      r_limit <= 1'b0;
    end else begin
      r_bcd   <= w_bcd_next;
      r_limit <= w_limit_next;
    end
  end

  // One 7-segment decoder per digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign leds[7*g +: 7] = seg7(r_bcd[4*g +: 4]);
  end

  assign bcd     = r_bcd;
  assign limit   = r_limit;
  assign at_zero = (r_bcd == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter (DIGITS=2, SYNC_STAGES=2).
// Stimulus pushes the expected count, limit flag and arrival cycle; a monitor
// treats any change of bcd, or a limit pulse, as a DUT output and pops/compares.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic        dir;
  logic        wrap_en;
  logic        load;
  logic [7:0]  load_val;
  logic [7:0]  bcd;
  logic [13:0] leds;
  logic        at_zero;
  logic        limit;

  bcd_updown_counter #(.DIGITS(2), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .step     (step),
    .dir      (dir),
    .wrap_en  (wrap_en),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .leds     (leds),
    .at_zero  (at_zero),
    .limit    (limit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bcd;
    logic       lim;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] prev_bcd = 8'h00;

  // Segment patterns, bit 0 = a ... bit 6 = g.
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [7:0] up_tab [12]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                               8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};

  function automatic logic [13:0] leds_of(input logic [7:0] v);
    return {seg_tab[int'(v[7:4])], seg_tab[int'(v[3:0])]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: an output event is a change of count or a limit pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_bcd = bcd;
    end else if (bcd !== prev_bcd || limit !== 1'b0) begin
      if (sb_q.size() == 0) begin
        check("spurious_output", 32'({limit, bcd}), 32'({1'b0, prev_bcd}));
      end else begin
        e = sb_q.pop_front();
        check("bcd",       32'(bcd),     32'(e.bcd));
        check("limit",     32'(limit),   32'(e.lim));
        check("latency",   32'(cyc),     32'(e.cyc));
        check("at_zero",   32'(at_zero), 32'(e.bcd == 8'h00));
        check("leds",      32'(leds),    32'(leds_of(e.bcd)));
      end
      prev_bcd = bcd;
    end
  end

  // One press: rise, hold for 'hold' clocks, release, settle.
  task automatic press(input int hold, input logic [7:0] eb, input logic el);
    int k;
    @(posedge clk);
    #1 step = 1'b1;
    k = cyc;
    sb_q.push_back('{bcd: eb, lim: el, cyc: k + 3});
    repeat (hold) @(posedge clk);
    #1 step = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v, input logic [7:0] eb);
    int k;
    @(posedge clk);
    #1 load = 1'b1;
    load_val = v;
    k = cyc;
    sb_q.push_back('{bcd: eb, lim: 1'b0, cyc: k + 1});
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b0; step = 1'b0; dir = 1'b0; wrap_en = 1'b1;
    load = 1'b0; load_val = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd",   32'(bcd),   32'h00);
    check("reset_limit", 32'(limit), 32'h0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("release_bcd",     32'(bcd),     32'h00);
    check("release_at_zero", 32'(at_zero), 32'h1);
    check("release_limit",   32'(limit),   32'h0);
    check("release_leds",    32'(leds),    32'({7'h3F, 7'h3F}));

    // Up count: 12 presses.
    for (int i = 0; i < 12; i++) press(5, up_tab[i], 1'b0);

    // Upper limit: wrap then saturate.
    do_load(8'h99, 8'h99);
    wrap_en = 1'b1;
    press(5, 8'h00, 1'b1);
    do_load(8'h99, 8'h99);
    wrap_en = 1'b0;
    press(5, 8'h99, 1'b1);

    // Borrow and lower limit: wrap then saturate.
    do_load(8'h10, 8'h10);
    dir = 1'b1;
    press(5, 8'h09, 1'b0);
    do_load(8'h00, 8'h00);
    wrap_en = 1'b1;
    press(5, 8'h99, 1'b1);
    do_load(8'h00, 8'h00);
    wrap_en = 1'b0;
    press(5, 8'h00, 1'b1);

    // Load clamp alone, then load coinciding with a step pulse.
    dir = 1'b0;
    wrap_en = 1'b1;
    do_load(8'h3B, 8'h39);
    @(posedge clk);
    #1 step = 1'b1;
    k = cyc;
    @(posedge clk);
    @(posedge clk);
    #1 load = 1'b1;
    load_val = 8'hC7;
    sb_q.push_back('{bcd: 8'h97, lim: 1'b0, cyc: k + 3});
    @(posedge clk);
    #1 load = 1'b0;
    check("load_pri_limit", 32'(limit), 32'h0);
    repeat (3) @(posedge clk);
    #1 step = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("load_pri_hold", 32'(bcd), 32'h97);

    // Long hold gives exactly one step.
    press(100, 8'h98, 1'b0);

    // Reset mid-press: cleared, and the held button must not step.
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_bcd",     32'(bcd),     32'h00);
    check("midreset_limit",   32'(limit),   32'h0);
    check("midreset_at_zero", 32'(at_zero), 32'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("held_after_reset", 32'(bcd), 32'h00);
    step = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    press(5, 8'h01, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
